// File: rtl/irq_pending_server_if.sv
// Request/offer bus between the pending-capture stage and its producer/consumer.
// The master side drives request lines, mask and handshake; the slave side offers indices.
interface irq_pending_server_if #(
    parameter int unsigned N_LINES = 8,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned CNT_W   = 8
);
    logic [N_LINES-1:0] req_in;
    logic [N_LINES-1:0] mask;
    logic               idx_ready;
    logic               ovf_clr;
    logic [IDX_W-1:0]   idx_out;
    logic               idx_valid;
    logic [N_LINES-1:0] pending;
    logic [N_LINES-1:0] overflow;
    logic [CNT_W-1:0]   serve_cnt;

    modport master (
        output req_in, mask, idx_ready, ovf_clr,
        input  idx_out, idx_valid, pending, overflow, serve_cnt
    );

    modport slave (
        input  req_in, mask, idx_ready, ovf_clr,
        output idx_out, idx_valid, pending, overflow, serve_cnt
    );
endinterface

// File: rtl/irq_pending_server.sv
// Sticky request capture with per-line mask, lowest-index-first offer over valid/ready,
// per-line lost-event flags and a wrapping served-event counter.
module irq_pending_server #(
    parameter int unsigned N_LINES   = 8,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned CNT_W     = 8,
    parameter bit          EDGE_MODE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    irq_pending_server_if.slave  bus_io
);

    typedef enum logic [0:0] {StIdle, StOffer} state_e;

    state_e             state_q, state_d;
    logic [N_LINES-1:0] req_q;
    logic [N_LINES-1:0] pending_q, pending_d;
    logic [N_LINES-1:0] overflow_q, overflow_d;
    logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [N_LINES-1:0] set_vec;
    logic [N_LINES-1:0] clr_vec;
    logic [N_LINES-1:0] eligible;
    logic [IDX_W-1:0]   lowest_idx;
    logic               accept;

    assign accept   = (state_q == StOffer) && bus_io.idx_ready;
    assign eligible = pending_q & ~bus_io.mask;
    assign set_vec  = EDGE_MODE ? (bus_io.req_in & ~req_q) : bus_io.req_in;

    always_comb begin
        clr_vec = '0;
        if (accept) begin
            clr_vec[idx_q] = 1'b1;
        end
    end

    // Scan from the top so the lowest set bit is the last assignment.
    always_comb begin
        lowest_idx = '0;
        for (int i = int'(N_LINES) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lowest_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        pending_d  = (pending_q & ~clr_vec) | set_vec;
        overflow_d = bus_io.ovf_clr ? '0 : overflow_q;
        if (EDGE_MODE) begin
            // A fresh overflow beats a same-cycle clear.
            overflow_d = overflow_d | (set_vec & pending_q & ~clr_vec);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        serve_cnt_d = serve_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (eligible != '0) begin
                    idx_d   = lowest_idx;
                    state_d = StOffer;
                end
            end
            StOffer: begin
                if (bus_io.idx_ready) begin
                    serve_cnt_d = serve_cnt_q + 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            req_q       <= '0;
            pending_q   <= '0;
            overflow_q  <= '0;
            serve_cnt_q <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= bus_io.req_in;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            serve_cnt_q <= serve_cnt_d;
            idx_q       <= idx_d;
        end
    end

    assign bus_io.idx_out   = idx_q;
    assign bus_io.idx_valid = (state_q == StOffer);
    assign bus_io.pending   = pending_q;
    assign bus_io.overflow  = overflow_q;
    assign bus_io.serve_cnt = serve_cnt_q;

endmodule

// File: tb/tb_irq_pending_server.sv
// Directed bench for irq_pending_server: per-cycle vector table for priority, hold, mask
// and overflow behaviour, plus hand sequences for reset, counter wrap and mid-offer reset.
module tb_irq_pending_server;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   served;

    always #5 clk = ~clk;

    irq_pending_server_if #(.N_LINES(8), .IDX_W(3), .CNT_W(8)) bus ();

    irq_pending_server #(
        .N_LINES   (8),
        .IDX_W     (3),
        .CNT_W     (8),
        .EDGE_MODE (1'b1)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        logic       rdy;
        logic       oclr;
        logic       e_valid;
        logic [2:0] e_idx;
        logic [7:0] e_pend;
        logic [7:0] e_ovf;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[36];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] req, input logic [7:0] mask, input logic rdy,
                        input logic oclr);
        bus.req_in    = req;
        bus.mask      = mask;
        bus.idx_ready = rdy;
        bus.ovf_clr   = oclr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // T2 priority drain
        vecs[0]  = '{8'hA4, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'hA4, 8'h00, 8'd0};
        vecs[1]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 8'hA4, 8'h00, 8'd0};
        vecs[2]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'hA0, 8'h00, 8'd1};
        vecs[3]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd5, 8'hA0, 8'h00, 8'd1};
        vecs[4]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 8'h00, 8'd2};
        vecs[5]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd7, 8'h80, 8'h00, 8'd2};
        vecs[6]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'd3};
        // T3 hold offer while stalled
        vecs[7]  = '{8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h40, 8'h00, 8'd3};
        vecs[8]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd6, 8'h40, 8'h00, 8'd3};
        vecs[9]  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd6, 8'h40, 8'h00, 8'd3};
        vecs[10] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd6, 8'h40, 8'h00, 8'd3};
        vecs[11] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd6, 8'h40, 8'h00, 8'd3};
        vecs[12] = '{8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 3'd6, 8'h42, 8'h00, 8'd3};
        vecs[13] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd6, 8'h42, 8'h00, 8'd3};
        vecs[14] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h02, 8'h00, 8'd4};
        vecs[15] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd1, 8'h02, 8'h00, 8'd4};
        vecs[16] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'd5};
        // T4 mask
        vecs[17] = '{8'h09, 8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 8'h09, 8'h00, 8'd5};
        vecs[18] = '{8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 3'd3, 8'h09, 8'h00, 8'd5};
        vecs[19] = '{8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 8'h01, 8'h00, 8'd6};
        vecs[20] = '{8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 8'h01, 8'h00, 8'd6};
        vecs[21] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 8'h00, 8'd6};
        vecs[22] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 8'h00, 8'd6};
        vecs[23] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'd7};
        // T5 overflow, set-wins, ovf_clr
        vecs[24] = '{8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h10, 8'h00, 8'd7};
        vecs[25] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 8'h00, 8'd7};
        vecs[26] = '{8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 8'h10, 8'd7};
        vecs[27] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 8'h10, 8'd7};
        vecs[28] = '{8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h10, 8'h10, 8'd8};
        vecs[29] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd4, 8'h10, 8'h00, 8'd8};
        vecs[30] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'd9};
        vecs[31] = '{8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h10, 8'h00, 8'd9};
        vecs[32] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 8'h00, 8'd9};
        vecs[33] = '{8'h10, 8'h00, 1'b0, 1'b1, 1'b1, 3'd4, 8'h10, 8'h10, 8'd9};
        vecs[34] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd4, 8'h10, 8'h00, 8'd9};
        vecs[35] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'd10};

        // T1: reset with all lines high
        bus.req_in    = 8'hFF;
        bus.mask      = 8'h00;
        bus.idx_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t1_rst_pending", 32'(bus.pending), 32'h00);
        chk("t1_rst_overflow", 32'(bus.overflow), 32'h00);
        chk("t1_rst_cnt", 32'(bus.serve_cnt), 32'h00);
        chk("t1_rst_valid", 32'(bus.idx_valid), 32'h0);
        chk("t1_rst_idx", 32'(bus.idx_out), 32'h0);
        rst = 1'b0;
        step(8'hFF, 8'h00, 1'b0, 1'b0);
        chk("t1_pending_ff", 32'(bus.pending), 32'hFF);
        chk("t1_valid_lat", 32'(bus.idx_valid), 32'h0);
        step(8'hFF, 8'h00, 1'b0, 1'b0);
        chk("t1_valid", 32'(bus.idx_valid), 32'h1);
        chk("t1_idx", 32'(bus.idx_out), 32'h0);

        rst = 1'b1;
        bus.req_in = 8'h00;
        #1;
        chk("t1_async_drop", 32'(bus.idx_valid), 32'h0);
        step(8'h00, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // T2..T5 table
        for (int i = 0; i < 36; i++) begin
            step(vecs[i].req, vecs[i].mask, vecs[i].rdy, vecs[i].oclr);
            chk($sformatf("v%0d_valid", i), 32'(bus.idx_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_idx", i), 32'(bus.idx_out), 32'(vecs[i].e_idx));
            end
            chk($sformatf("v%0d_pending", i), 32'(bus.pending), 32'(vecs[i].e_pend));
            chk($sformatf("v%0d_overflow", i), 32'(bus.overflow), 32'(vecs[i].e_ovf));
            chk($sformatf("v%0d_cnt", i), 32'(bus.serve_cnt), 32'(vecs[i].e_cnt));
        end

        // T6: drive the counter through its wrap
        served = 10;
        for (int n = 0; n < 246; n++) begin
            step(8'h01, 8'h00, 1'b1, 1'b0);
            step(8'h00, 8'h00, 1'b1, 1'b0);
            if (n % 41 == 0) begin
                chk("t6_offer_idx", 32'(bus.idx_out), 32'h0);
            end
            step(8'h00, 8'h00, 1'b1, 1'b0);
            served++;
        end
        chk("t6_wrap_cnt", 32'(bus.serve_cnt), 32'(8'(served)));
        chk("t6_wrap_pending", 32'(bus.pending), 32'h00);

        // Offer line 2, then reset in the middle of the offer with ready held
        step(8'h04, 8'h00, 1'b0, 1'b0);
        step(8'h00, 8'h00, 1'b0, 1'b0);
        chk("t6_offer_valid", 32'(bus.idx_valid), 32'h1);
        chk("t6_offer_idx2", 32'(bus.idx_out), 32'h2);
        #2;
        bus.idx_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(bus.idx_valid), 32'h0);
        chk("t6_rst_pending", 32'(bus.pending), 32'h00);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        rst = 1'b0;
        step(8'h00, 8'h00, 1'b1, 1'b0);
        chk("t6_post_cnt", 32'(bus.serve_cnt), 32'h00);
        chk("t6_post_valid", 32'(bus.idx_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
